// File: rtl/mac_sequencer.sv
// Sequences one MultAccum through a dot product of Len sample/kernel pairs read from two sync-read memories.
// Optional build macro CONV_AUTO_SLIDE_EN: Start held at the result handshake restarts with SampleBase+1.
module mac_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int LEN_W   = 9,
  parameter int ACC_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [LEN_W-1:0]  Len,
  input  logic [ADDR_W-1:0] SampleBase,
  output logic              Busy,
  output logic [ADDR_W-1:0] SampleAddr,
  output logic [ADDR_W-1:0] KernelAddr,
  input  logic [7:0]        SampleData,
  input  logic [7:0]        KernelData,
  output logic [7:0]        MacX,
  output logic [7:0]        MacY,
  output logic              MacAccumReset,
  input  logic [31:0]       MacLocalReg,
  output logic [31:0]       Result,
  output logic              ResultValid,
  input  logic              ResultReady
);

  localparam int DRAIN_W = $clog2(ACC_LAT + 2);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    tap_q, tap_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [ADDR_W-1:0]   saddr_q, saddr_d;
  logic [ADDR_W-1:0]   kaddr_q, kaddr_d;
  logic [31:0]         result_q, result_d;
  logic                valid_q, valid_d;
  logic [LEN_W-1:0]    tap_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      base_q   <= '0;
      tap_q    <= '0;
      drain_q  <= '0;
      saddr_q  <= '0;
      kaddr_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      base_q   <= base_d;
      tap_q    <= tap_d;
      drain_q  <= drain_d;
      saddr_q  <= saddr_d;
      kaddr_q  <= kaddr_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    base_d   = base_q;
    tap_d    = tap_q;
    drain_d  = drain_q;
    saddr_d  = saddr_q;
    kaddr_d  = kaddr_q;
    result_d = result_q;
    valid_d  = (state_q == RUN);
    tap_next = tap_q + LEN_W'(1);

    case (state_q)
      IDLE: begin
        if (Start) begin
          len_d   = Len;
          base_d  = SampleBase;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        tap_d   = '0;
        drain_d = '0;
        if (len_q == '0) begin
          result_d = '0;
          state_d  = DONE;
        end else begin
          saddr_d = base_q;
          kaddr_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        tap_d = tap_next;
        // Addresses hold on the last tap, so they always show the last pair issued.
        if (tap_q == len_q - LEN_W'(1)) begin
          state_d = DRAIN;
        end else begin
          saddr_d = base_q + ADDR_W'(tap_next);
          kaddr_d = ADDR_W'(tap_next);
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_W'(ACC_LAT)) begin
          result_d = MacLocalReg;
          state_d  = DONE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      DONE: begin
        if (ResultReady) begin
`ifdef CONV_AUTO_SLIDE_EN
          if (Start) begin
            base_d  = base_q + ADDR_W'(1);
            state_d = CLEAR;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are zeroed outside valid read-data cycles so the accumulator holds its value.
  assign MacX          = valid_q ? SampleData : 8'd0;
  assign MacY          = valid_q ? KernelData : 8'd0;
  assign Busy          = (state_q != IDLE);
  assign MacAccumReset = (state_q == CLEAR);
  assign ResultValid   = (state_q == DONE);
  assign Result        = result_q;
  assign SampleAddr    = saddr_q;
  assign KernelAddr    = kaddr_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with sync-read memory and MultAccum (ACC_LAT=1) models.
// Covers reset, dot product, zero length, backpressure/wrap, max magnitude and restart behaviour.
module tb_mac_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [8:0]  Len;
  logic [9:0]  SampleBase;
  logic        Busy;
  logic [9:0]  SampleAddr;
  logic [9:0]  KernelAddr;
  logic [7:0]  SampleData;
  logic [7:0]  KernelData;
  logic [7:0]  MacX;
  logic [7:0]  MacY;
  logic        MacAccumReset;
  logic [31:0] MacLocalReg;
  logic [31:0] Result;
  logic        ResultValid;
  logic        ResultReady;

  logic [7:0]  smem [0:1023];
  logic [7:0]  kmem [0:1023];

  int nVectors;
  int nMiscompares;

  mac_sequencer #(.ADDR_W(10), .LEN_W(9), .ACC_LAT(1)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .Len          (Len),
    .SampleBase   (SampleBase),
    .Busy         (Busy),
    .SampleAddr   (SampleAddr),
    .KernelAddr   (KernelAddr),
    .SampleData   (SampleData),
    .KernelData   (KernelData),
    .MacX         (MacX),
    .MacY         (MacY),
    .MacAccumReset(MacAccumReset),
    .MacLocalReg  (MacLocalReg),
    .Result       (Result),
    .ResultValid  (ResultValid),
    .ResultReady  (ResultReady)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    SampleData <= smem[SampleAddr];
    KernelData <= kmem[KernelAddr];
  end

  // MultAccum stand-in: one cycle from operands to LocalReg.
  always @(posedge Clk or posedge Reset) begin
    if (Reset)              MacLocalReg <= 32'd0;
    else if (MacAccumReset) MacLocalReg <= 32'd0;
    else                    MacLocalReg <= MacLocalReg + ({24'd0, MacX} * {24'd0, MacY});
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nVectors++;
    assert (observed === expected)
    else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] len, input logic [9:0] base, input logic hold);
    Start      = 1'b1;
    Len        = len;
    SampleBase = base;
    tick();
    if (!hold) Start = 1'b0;
  endtask

  // Edge count includes the edge that sampled Start.
  task automatic waitResult(input int bound, output int edges, output int clears);
    edges  = 1;
    clears = 0;
    while (!ResultValid && edges < bound) begin
      if (MacAccumReset) clears++;
      tick();
      edges++;
    end
  endtask

  initial begin
    int edges;
    int clears;
    int gap;
    logic sawValid;
    logic busyDropped;

    nVectors     = 0;
    nMiscompares = 0;
    Reset        = 1'b1;
    Start        = 1'b0;
    Len          = '0;
    SampleBase   = '0;
    ResultReady  = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      smem[k] = 8'd0;
      kmem[k] = 8'd0;
    end
    smem[0] = 8'd1; smem[1] = 8'd2; smem[2] = 8'd3; smem[3] = 8'd4;
    kmem[0] = 8'd5; kmem[1] = 8'd6; kmem[2] = 8'd7; kmem[3] = 8'd8;

    #17;
    checkOutput("rst_busy", {31'd0, Busy}, 32'd0);
    checkOutput("rst_valid", {31'd0, ResultValid}, 32'd0);
    checkOutput("rst_result", Result, 32'd0);
    checkOutput("rst_saddr", {22'd0, SampleAddr}, 32'd0);
    checkOutput("rst_kaddr", {22'd0, KernelAddr}, 32'd0);
    checkOutput("rst_macx", {24'd0, MacX}, 32'd0);
    checkOutput("rst_accrst", {31'd0, MacAccumReset}, 32'd0);
    Reset = 1'b0;
    tick();

    $display("[TB] reset during RUN");
    applyStimulus(9'd4, 10'd0, 1'b0);
    tick();
    tick();
    checkOutput("midrun_busy_before", {31'd0, Busy}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    checkOutput("midrun_busy", {31'd0, Busy}, 32'd0);
    checkOutput("midrun_valid", {31'd0, ResultValid}, 32'd0);
    #2 Reset = 1'b0;
    sawValid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ResultValid || Busy) sawValid = 1'b1;
    end
    checkOutput("midrun_no_result", {31'd0, sawValid}, 32'd0);

    $display("[TB] dot product Len=4");
    applyStimulus(9'd4, 10'd0, 1'b0);
    waitResult(50, edges, clears);
    checkOutput("dot_valid", {31'd0, ResultValid}, 32'd1);
    checkOutput("dot_edges", edges, 32'd8);
    checkOutput("dot_clears", clears, 32'd1);
    checkOutput("dot_result", Result, 32'd70);
    tick();
    checkOutput("dot_valid_drop", {31'd0, ResultValid}, 32'd0);
    checkOutput("dot_idle", {31'd0, Busy}, 32'd0);

    $display("[TB] zero length");
    applyStimulus(9'd0, 10'd100, 1'b0);
    waitResult(20, edges, clears);
    checkOutput("zero_valid", {31'd0, ResultValid}, 32'd1);
    checkOutput("zero_edges", edges, 32'd2);
    checkOutput("zero_result", Result, 32'd0);
    checkOutput("zero_saddr", {22'd0, SampleAddr}, 32'd3);
    checkOutput("zero_kaddr", {22'd0, KernelAddr}, 32'd3);
    tick();
    checkOutput("zero_valid_drop", {31'd0, ResultValid}, 32'd0);

    $display("[TB] backpressure and address wrap");
    smem[1022] = 8'd255; smem[1023] = 8'd255; smem[0] = 8'd255;
    kmem[0] = 8'd255; kmem[1] = 8'd255; kmem[2] = 8'd255;
    ResultReady = 1'b0;
    applyStimulus(9'd3, 10'd1022, 1'b0);
    Start      = 1'b1;
    Len        = 9'd7;
    SampleBase = 10'd5;
    tick();
    tick();
    Start = 1'b0;
    waitResult(50, edges, clears);
    checkOutput("bp_saddr_wrap", {22'd0, SampleAddr}, 32'd0);
    checkOutput("bp_kaddr", {22'd0, KernelAddr}, 32'd2);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_valid_hold", {31'd0, ResultValid}, 32'd1);
      checkOutput("bp_result_hold", Result, 32'd195075);
      tick();
    end
    ResultReady = 1'b1;
    tick();
    checkOutput("bp_valid_drop", {31'd0, ResultValid}, 32'd0);
    checkOutput("bp_idle", {31'd0, Busy}, 32'd0);

    $display("[TB] max magnitude Len=511");
    for (int k = 0; k < 1024; k++) begin
      smem[k] = 8'd255;
      kmem[k] = 8'd255;
    end
    applyStimulus(9'd511, 10'd0, 1'b0);
    waitResult(600, edges, clears);
    checkOutput("max_valid", {31'd0, ResultValid}, 32'd1);
    checkOutput("max_edges", edges, 32'd515);
    checkOutput("max_result", Result, 32'd33227775);
    tick();

    $display("[TB] Start held across result handshake");
    smem[0] = 8'd1; smem[1] = 8'd2; smem[2] = 8'd3; smem[3] = 8'd4; smem[4] = 8'd5;
    kmem[0] = 8'd1; kmem[1] = 8'd1; kmem[2] = 8'd1;
    applyStimulus(9'd3, 10'd0, 1'b1);
    waitResult(30, edges, clears);
    checkOutput("win0_valid", {31'd0, ResultValid}, 32'd1);
    checkOutput("win0_edges", edges, 32'd7);
    checkOutput("win0_result", Result, 32'd6);
`ifdef CONV_AUTO_SLIDE_EN
    busyDropped = 1'b0;
    for (int w = 1; w < 3; w++) begin
      gap = 0;
      tick();
      while (!ResultValid && gap < 40) begin
        if (!Busy) busyDropped = 1'b1;
        gap++;
        tick();
      end
      checkOutput("slide_gap", gap, 32'd6);
      checkOutput("slide_result", Result, (w == 1) ? 32'd9 : 32'd12);
    end
    checkOutput("slide_busy_held", {31'd0, busyDropped}, 32'd0);
    Start = 1'b0;
    tick();
    checkOutput("slide_release_idle", {31'd0, Busy}, 32'd0);
`else
    busyDropped = 1'b0;
    tick();
    checkOutput("noslide_idle", {31'd0, Busy}, 32'd0);
    tick();
    checkOutput("noslide_restart", {31'd0, Busy}, 32'd1);
    Start = 1'b0;
    gap = 0;
    while (!ResultValid && gap < 30) begin
      gap++;
      tick();
    end
    checkOutput("noslide_valid", {31'd0, ResultValid}, 32'd1);
    checkOutput("noslide_result", Result, 32'd6);
    tick();
    checkOutput("noslide_release_idle", {31'd0, Busy}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
